drone_plant: RTL

DRONE_PLANT -- requirements
Module: drone_plant

---
 rtl/drone_plant.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/drone_plant.sv
// drone_plant: two-floor delivery drone plant model.
// Position FSM (DOCK5/UP/DOCK6/DOWN) with a travel counter, a one-entry
// package buffer, latched call buttons, a delivery counter and a sticky
// protocol fault flag.
// Ports:
//   clk, rst_n         clock, synchronous active-low reset
//   Motor[1:0]         [0] ascend toward floor 6, [1] descend toward floor 5
//   Drop[1:0]          [0] release at floor 5, [1] release at floor 6
//   call_req[1:0]      call button pulses, [0] floor 5, [1] floor 6
//   pkg_valid/pkg_dest package offer and its destination (0 = floor 5)
//   pkg_ready          package buffer empty
//   Floor[1:0]         docked indication, [0] floor 5, [1] floor 6
//   FS[1:0]            docked at floor i holding a package for floor i
//   Call[1:0]          latched pending calls
//   err                sticky protocol fault
//   deliv_cnt[7:0]     completed deliveries (wraps)
module drone_plant #(
  parameter int unsigned TRAVEL = 8,
  parameter int unsigned CNT_W  = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] Motor,
  input  logic [1:0] Drop,
  input  logic [1:0] call_req,
  input  logic       pkg_valid,
  input  logic       pkg_dest,
  output logic       pkg_ready,
  output logic [1:0] Floor,
  output logic [1:0] FS,
  output logic [1:0] Call,
  output logic       err,
  output logic [7:0] deliv_cnt
);

  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(TRAVEL - 1);

  typedef enum logic [1:0] {DOCK5, UP, DOCK6, DOWN} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             full_q, full_d;
  logic             dest_q, dest_d;
  logic [1:0]       fs_q, fs_d;
  logic [1:0]       call_q, call_d;
  logic             err_q, err_d;
  logic [7:0]       deliv_q, deliv_d;
  logic [1:0]       floor_q, floor_d;
  logic             ready_q, ready_d;

  logic [1:0] docked;
  logic [1:0] drop_ok;
  logic [1:0] drop_bad;
  logic       accept;

  // Next-state and output logic
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    full_d   = full_q;
    dest_d   = dest_q;
    fs_d     = 2'b00;
    call_d   = call_q;
    err_d    = err_q;
    deliv_d  = deliv_q;
    floor_d  = 2'b00;
    ready_d  = ready_q;
    docked   = {state_q == DOCK6, state_q == DOCK5};
    drop_ok  = Drop & fs_q;
    drop_bad = Drop & ~fs_q;
    accept   = pkg_valid & ~full_q;

    unique case (state_q)
      DOCK5: if (Motor == 2'b01) begin
        state_d = UP;
        cnt_d   = CNT_TOP;
      end
      DOCK6: if (Motor == 2'b10) begin
        state_d = DOWN;
        cnt_d   = CNT_TOP;
      end
      UP: begin
        case (Motor)
          2'b01: begin
            if (cnt_q == '0) state_d = DOCK6;
            else             cnt_d   = cnt_q - CNT_W'(1);
          end
          2'b10: begin
            // Reversal: remaining distance becomes distance already covered
            state_d = DOWN;
            cnt_d   = CNT_TOP - cnt_q;
          end
          default: ;
        endcase
      end
      DOWN: begin
        case (Motor)
          2'b10: begin
            if (cnt_q == '0) state_d = DOCK5;
            else             cnt_d   = cnt_q - CNT_W'(1);
          end
          2'b01: begin
            state_d = UP;
            cnt_d   = CNT_TOP - cnt_q;
          end
          default: ;
        endcase
      end
      default: ;
    endcase

    if (accept) begin
      full_d = 1'b1;
      dest_d = pkg_dest;
    end else if (|drop_ok) begin
      full_d = 1'b0;
    end

    // FS drops together with the delivery so a second Drop cannot count twice
    fs_d = {full_q & dest_q & docked[1], full_q & ~dest_q & docked[0]} & ~drop_ok;

    call_d = call_req | (call_q & ~drop_ok);
    err_d  = err_q | (Motor == 2'b11) | (|drop_bad);
    if (|drop_ok) deliv_d = deliv_q + 8'd1;

    case (state_d)
      DOCK5:   floor_d = 2'b01;
      DOCK6:   floor_d = 2'b10;
      default: floor_d = 2'b00;
    endcase
    ready_d = ~full_d;
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= DOCK5;
      cnt_q   <= '0;
      full_q  <= 1'b0;
      dest_q  <= 1'b0;
      fs_q    <= 2'b00;
      call_q  <= 2'b00;
      err_q   <= 1'b0;
      deliv_q <= 8'd0;
      floor_q <= 2'b01;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      full_q  <= full_d;
      dest_q  <= dest_d;
      fs_q    <= fs_d;
      call_q  <= call_d;
      err_q   <= err_d;
      deliv_q <= deliv_d;
      floor_q <= floor_d;
      ready_q <= ready_d;
    end
  end

  assign pkg_ready = ready_q;
  assign Floor     = floor_q;
  assign FS        = fs_q;
  assign Call      = call_q;
  assign err       = err_q;
  assign deliv_cnt = deliv_q;

endmodule
